mac_pu_0: RTL and testbench

Processing unit answering the streamline local controller: consumes `pu_en`/`pu_valid`/`pu_clear` strobes plus paired din1/din2 operand words read from the input buffers, performs MAC_NUM-lane signed multiply-accumulate, and emits one accumulated result per output column.

Each result carries a column index for the downstream result buffer. The block asserts done after COLUMN results have been emitted.

---
 rtl/mac_pu_0.sv | 155 +++++++++++++++
 tb/tb_mac_pu_0.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mac_pu_0.sv
// MAC_NUM-lane signed multiply-accumulate unit emitting one result per output column.
// Define MAC_PU_SATURATE_EN to clamp the accumulator on overflow; otherwise it wraps.
module mac_pu_0 #(
    parameter int MAC_NUM = 8,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int COLUMN  = 8
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          pu_en_i,
    input  logic                          pu_valid_i,
    input  logic                          pu_clear_i,
    input  logic [MAC_NUM*DATA_W-1:0]     din1_i,
    input  logic [MAC_NUM*DATA_W-1:0]     din2_i,
    output logic signed [ACC_W-1:0]       result_o,
    output logic                          result_valid_o,
    output logic [$clog2(COLUMN)-1:0]     result_addr_o,
    output logic                          overflow_o,
    output logic                          done_o
);

    localparam int ADDR_W = $clog2(COLUMN);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLUMN - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    function automatic logic signed [2*DATA_W-1:0] lane_mul(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        lane_mul = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    endfunction

    // Result of an accumulate step; only differs from the raw sum when the add overflowed.
    function automatic logic signed [ACC_W-1:0] clamp(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] sum,
        input logic                    ovf
    );
`ifdef MAC_PU_SATURATE_EN
        if (ovf)
            clamp = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        else
            clamp = sum;
`else
        clamp = (ovf && 1'b0) ? a : sum;
`endif
    endfunction

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc_p0, acc_nxt;
    logic [ADDR_W-1:0]        col_p0, col_nxt;
    logic signed [ACC_W-1:0]  res_p0, res_nxt;
    logic [ADDR_W-1:0]        addr_p0, addr_nxt;
    logic                     vld_p0, vld_nxt;
    logic                     ovf_p0, ovf_nxt;

    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  sum;
    logic                     add_ovf;

    always_comb begin
        term = '0;
        for (int k = 0; k < MAC_NUM; k++) begin
            term = term + ACC_W'(lane_mul(din1_i[k*DATA_W +: DATA_W],
                                          din2_i[k*DATA_W +: DATA_W]));
        end
    end

    // Overflow only when both addends share a sign that the sum does not.
    assign sum     = acc_p0 + term;
    assign add_ovf = (acc_p0[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc_p0[ACC_W-1]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc_p0;
        col_nxt   = col_p0;
        res_nxt   = res_p0;
        addr_nxt  = addr_p0;
        vld_nxt   = 1'b0;
        ovf_nxt   = ovf_p0;
        if (pu_clear_i) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            col_nxt   = '0;
            res_nxt   = '0;
            addr_nxt  = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pu_en_i) begin
                        state_nxt = ACCUM;
                        acc_nxt   = term;
                    end
                end
                ACCUM: begin
                    if (pu_valid_i) begin
                        res_nxt  = acc_p0;
                        addr_nxt = col_p0;
                        vld_nxt  = 1'b1;
                        // A coincident pu_en_i opens the next column with this cycle's term.
                        acc_nxt  = pu_en_i ? term : '0;
                        if (col_p0 == LAST_COL)
                            state_nxt = DONE;
                        else
                            col_nxt = col_p0 + 1'b1;
                    end else if (pu_en_i) begin
                        acc_nxt = clamp(acc_p0, sum, add_ovf);
                        ovf_nxt = ovf_p0 | add_ovf;
                    end
                end
                DONE: begin
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage p0: accumulator and registered result outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_p0  <= '0;
            col_p0  <= '0;
            res_p0  <= '0;
            addr_p0 <= '0;
            vld_p0  <= 1'b0;
            ovf_p0  <= 1'b0;
        end else begin
            acc_p0  <= acc_nxt;
            col_p0  <= col_nxt;
            res_p0  <= res_nxt;
            addr_p0 <= addr_nxt;
            vld_p0  <= vld_nxt;
            ovf_p0  <= ovf_nxt;
        end
    end

    assign result_o       = res_p0;
    assign result_valid_o = vld_p0;
    assign result_addr_o  = addr_p0;
    assign overflow_o     = ovf_p0;
    assign done_o         = (state == DONE);

endmodule

// File: tb/tb_mac_pu_0.sv
// Directed self-checking bench for mac_pu_0: default instance plus a 1-lane ACC_W=16 instance for overflow.
module tb_mac_pu_0;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        en = 0, valid = 0, clear = 0;
    logic [63:0] d1 = '0, d2 = '0;
    logic signed [31:0] res;
    logic        rvld, ovf, done;
    logic [2:0]  addr;

    logic        en16 = 0, valid16 = 0, clear16 = 0;
    logic [7:0]  a16 = '0, b16 = '0;
    logic signed [15:0] res16;
    logic        rvld16, ovf16, done16;
    logic [2:0]  addr16;

    int checks = 0;
    int fails  = 0;

    mac_pu_0 dut (
        .clk_i(clk), .rstn_i(rstn), .pu_en_i(en), .pu_valid_i(valid), .pu_clear_i(clear),
        .din1_i(d1), .din2_i(d2), .result_o(res), .result_valid_o(rvld),
        .result_addr_o(addr), .overflow_o(ovf), .done_o(done)
    );

    mac_pu_0 #(.MAC_NUM(1), .DATA_W(8), .ACC_W(16), .COLUMN(8)) dut16 (
        .clk_i(clk), .rstn_i(rstn), .pu_en_i(en16), .pu_valid_i(valid16), .pu_clear_i(clear16),
        .din1_i(a16), .din2_i(b16), .result_o(res16), .result_valid_o(rvld16),
        .result_addr_o(addr16), .overflow_o(ovf16), .done_o(done16)
    );

    task automatic drive(input logic e, input logic v, input logic c,
                         input logic [63:0] x, input logic [63:0] y);
        en = e; valid = v; clear = c; d1 = x; d2 = y;
        @(posedge clk); #1;
        en = 0; valid = 0; clear = 0; d1 = '0; d2 = '0;
    endtask

    task automatic drive16(input logic e, input logic v, input logic c,
                           input logic [7:0] x, input logic [7:0] y);
        en16 = e; valid16 = v; clear16 = c; a16 = x; b16 = y;
        @(posedge clk); #1;
        en16 = 0; valid16 = 0; clear16 = 0; a16 = '0; b16 = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (res !== 32'sd0) begin $display("FAIL reset_result got=%0d exp=0", res); fails++; end
        checks++; if (rvld !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", rvld); fails++; end
        checks++; if (addr !== 3'd0) begin $display("FAIL reset_addr got=%0d exp=0", addr); fails++; end
        checks++; if (ovf !== 1'b0) begin $display("FAIL reset_ovf got=%b exp=0", ovf); fails++; end
        checks++; if (done !== 1'b0) begin $display("FAIL reset_done got=%b exp=0", done); fails++; end
        checks++; if (res16 !== 16'sd0) begin $display("FAIL reset_result16 got=%0d exp=0", res16); fails++; end
        rstn = 1'b1;
    endtask

    task automatic test_idle_valid();
        drive(0, 1, 0, '0, '0);
        checks++; if (rvld !== 1'b0) begin $display("FAIL idle_valid got=%b exp=0", rvld); fails++; end
    endtask

    task automatic test_all_lanes();
        repeat (4) drive(1, 0, 0, {8{8'h01}}, {8{8'h02}});
        drive(0, 1, 0, '0, '0);
        checks++; if (res !== 32'sd64) begin $display("FAIL all_lanes_result got=%0d exp=64", res); fails++; end
        checks++; if (addr !== 3'd0) begin $display("FAIL all_lanes_addr got=%0d exp=0", addr); fails++; end
        checks++; if (rvld !== 1'b1) begin $display("FAIL all_lanes_valid got=%b exp=1", rvld); fails++; end
        drive(0, 0, 0, '0, '0);
        checks++; if (rvld !== 1'b0) begin $display("FAIL all_lanes_pulse got=%b exp=0", rvld); fails++; end
        drive(0, 0, 1, '0, '0);
    endtask

    task automatic test_negative();
        repeat (2) drive(1, 0, 0, 64'(8'hFD), 64'(8'h05));
        drive(0, 1, 0, '0, '0);
        checks++; if (res !== -32'sd30) begin $display("FAIL negative_result got=%0d exp=-30", res); fails++; end
        checks++; if (addr !== 3'd0) begin $display("FAIL negative_addr got=%0d exp=0", addr); fails++; end
        drive(0, 0, 1, '0, '0);
    endtask

    task automatic test_columns();
        for (int c = 0; c < 8; c++) begin
            drive(1, 0, 0, 64'(c + 1), 64'(1));
            drive(0, 1, 0, '0, '0);
            checks++; if (res !== 32'(c + 1)) begin $display("FAIL col%0d_result got=%0d exp=%0d", c, res, c + 1); fails++; end
            checks++; if (addr !== 3'(c)) begin $display("FAIL col%0d_addr got=%0d exp=%0d", c, addr, c); fails++; end
            checks++; if (rvld !== 1'b1) begin $display("FAIL col%0d_valid got=%b exp=1", c, rvld); fails++; end
            checks++; if (done !== (c == 7)) begin $display("FAIL col%0d_done got=%b exp=%b", c, done, c == 7); fails++; end
        end
        drive(1, 1, 0, 64'(1), 64'(1));
        checks++; if (rvld !== 1'b0) begin $display("FAIL done_ignore_valid got=%b exp=0", rvld); fails++; end
        checks++; if (done !== 1'b1) begin $display("FAIL done_hold got=%b exp=1", done); fails++; end
        drive(0, 0, 1, '0, '0);
        checks++; if (done !== 1'b0) begin $display("FAIL clear_done got=%b exp=0", done); fails++; end
        checks++; if (res !== 32'sd0) begin $display("FAIL clear_result got=%0d exp=0", res); fails++; end
        checks++; if (addr !== 3'd0) begin $display("FAIL clear_addr got=%0d exp=0", addr); fails++; end
        checks++; if (rvld !== 1'b0) begin $display("FAIL clear_valid got=%b exp=0", rvld); fails++; end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 0, 64'(10), 64'(1));
        drive(1, 1, 0, 64'(1), 64'(1));
        checks++; if (res !== 32'sd10) begin $display("FAIL b2b_first got=%0d exp=10", res); fails++; end
        checks++; if (addr !== 3'd0) begin $display("FAIL b2b_first_addr got=%0d exp=0", addr); fails++; end
        drive(0, 1, 0, '0, '0);
        checks++; if (res !== 32'sd1) begin $display("FAIL b2b_second got=%0d exp=1", res); fails++; end
        checks++; if (addr !== 3'd1) begin $display("FAIL b2b_second_addr got=%0d exp=1", addr); fails++; end
        drive(0, 0, 1, '0, '0);
    endtask

    task automatic test_overflow();
        logic signed [15:0] exp16;
`ifdef MAC_PU_SATURATE_EN
        exp16 = 16'sd32767;
`else
        exp16 = -16'sd17149;
`endif
        drive16(1, 0, 0, 8'd127, 8'd127);
        drive16(1, 0, 0, 8'd127, 8'd127);
        checks++; if (ovf16 !== 1'b0) begin $display("FAIL ovf_early got=%b exp=0", ovf16); fails++; end
        drive16(1, 0, 0, 8'd127, 8'd127);
        checks++; if (ovf16 !== 1'b1) begin $display("FAIL ovf_set got=%b exp=1", ovf16); fails++; end
        drive16(0, 1, 0, '0, '0);
        checks++; if (res16 !== exp16) begin $display("FAIL ovf_result got=%0d exp=%0d", res16, exp16); fails++; end
        checks++; if (ovf16 !== 1'b1) begin $display("FAIL ovf_sticky got=%b exp=1", ovf16); fails++; end
        drive16(0, 0, 1, '0, '0);
        checks++; if (ovf16 !== 1'b0) begin $display("FAIL ovf_clear got=%b exp=0", ovf16); fails++; end
    endtask

    task automatic test_reset_midrun();
        drive(1, 0, 0, 64'(3), 64'(1));
        drive(1, 1, 0, 64'(2), 64'(1));
        checks++; if (res !== 32'sd3) begin $display("FAIL midrun_pre got=%0d exp=3", res); fails++; end
        #2 rstn = 1'b0;
        #1;
        checks++; if (res !== 32'sd0) begin $display("FAIL midrun_rst_result got=%0d exp=0", res); fails++; end
        checks++; if (rvld !== 1'b0) begin $display("FAIL midrun_rst_valid got=%b exp=0", rvld); fails++; end
        @(posedge clk); #1;
        rstn = 1'b1;
        drive(1, 0, 0, 64'(5), 64'(1));
        drive(0, 1, 0, '0, '0);
        checks++; if (res !== 32'sd5) begin $display("FAIL midrun_after got=%0d exp=5", res); fails++; end
        checks++; if (addr !== 3'd0) begin $display("FAIL midrun_addr got=%0d exp=0", addr); fails++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_idle_valid();
        test_all_lanes();
        test_negative();
        test_columns();
        test_back_to_back();
        test_overflow();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
